// File: rtl/code_lock_ctrl.sv
// Two-digit code-lock controller: digit sequencing, code compare, failure lockout, reprogramming.
// Optional partial-entry timeout enabled by defining CODE_LOCK_TIMEOUT_EN.
module code_lock_ctrl #(
    parameter logic [7:0] DEFAULT_CODE = 8'h35,
    parameter int         MAX_FAIL     = 3,
    parameter int         LOCK_CYCLES  = 16,
    parameter int         IDLE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       confirm,
    input  logic       setCode,
    input  logic       lock,
    output logic [3:0] dout,
    output logic       enLeft,
    output logic       enRight,
    output logic       unlocked,
    output logic       errPulse,
    output logic       lockedOut,
    output logic       progDone,
    output logic [3:0] failCnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GOT1    = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        PROG1   = 3'd4,
        PROG2   = 3'd5,
        LOCKOUT = 3'd6
    } state_t;

    localparam int            TW        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
    localparam logic [3:0]    MAX_F     = 4'(MAX_FAIL);

    state_t        state_q, state_d;
    logic          confirm_q, armed_q;
    logic [3:0]    first_q, first_d;
    logic [7:0]    code_q, code_d;
    logic [3:0]    fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    dout_q, dout_d;
    logic          en_left_q, en_left_d, en_right_q, en_right_d;
    logic          err_q, err_d, prog_done_q, prog_done_d;
    logic          unlocked_q, locked_out_q;
    logic          press_s, timeout_s;

    // armed_q blocks a press that was already held when reset was released
    assign press_s = confirm & ~confirm_q & armed_q;

`ifdef CODE_LOCK_TIMEOUT_EN
    localparam int TOW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TOW-1:0] TMO_LAST = TOW'(IDLE_TIMEOUT - 1);
    logic [TOW-1:0] tmo_q;
    logic           waiting_s;

    assign waiting_s = (state_q == GOT1) || (state_q == PROG1) || (state_q == PROG2);
    assign timeout_s = waiting_s && (tmo_q == TMO_LAST);

    // Inactivity counter, restarted on each accepted press or state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (press_s || !waiting_s || (state_d != state_q)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TOW'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        code_d      = code_q;
        fail_d      = fail_q;
        timer_d     = timer_q;
        dout_d      = dout_q;
        en_left_d   = 1'b0;
        en_right_d  = 1'b0;
        err_d       = 1'b0;
        prog_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_s) begin
                    first_d   = din;
                    dout_d    = din;
                    en_left_d = 1'b1;
                    state_d   = GOT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GOT1: begin
                if (press_s) begin
                    dout_d     = din;
                    en_right_d = 1'b1;
                    state_d    = CHECK;
                end else if (timeout_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GOT1;
                end
            end
            CHECK: begin
                // dout_q still holds the second digit here
                if ({first_q, dout_q} == code_q) begin
                    fail_d  = 4'd0;
                    state_d = OPEN;
                end else if ((fail_q + 4'd1) >= MAX_F) begin
                    err_d   = 1'b1;
                    fail_d  = MAX_F;
                    timer_d = LOCK_LOAD;
                    state_d = LOCKOUT;
                end else begin
                    err_d   = 1'b1;
                    fail_d  = fail_q + 4'd1;
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_d  = 4'd0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            OPEN: begin
                if (lock) begin
                    state_d = IDLE;
                end else if (setCode) begin
                    state_d = PROG1;
                end else begin
                    state_d = OPEN;
                end
            end
            PROG1: begin
                if (lock) begin
                    state_d = IDLE;
                end else if (press_s) begin
                    first_d   = din;
                    dout_d    = din;
                    en_left_d = 1'b1;
                    state_d   = PROG2;
                end else if (timeout_s) begin
                    state_d = OPEN;
                end else begin
                    state_d = PROG1;
                end
            end
            PROG2: begin
                if (lock) begin
                    state_d = IDLE;
                end else if (press_s) begin
                    dout_d      = din;
                    en_right_d  = 1'b1;
                    code_d      = {first_q, din};
                    prog_done_d = 1'b1;
                    state_d     = OPEN;
                end else if (timeout_s) begin
                    state_d = OPEN;
                end else begin
                    state_d = PROG2;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            confirm_q    <= 1'b0;
            armed_q      <= 1'b0;
            first_q      <= 4'd0;
            code_q       <= DEFAULT_CODE;
            fail_q       <= 4'd0;
            timer_q      <= '0;
            dout_q       <= 4'd0;
            en_left_q    <= 1'b0;
            en_right_q   <= 1'b0;
            err_q        <= 1'b0;
            prog_done_q  <= 1'b0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            confirm_q    <= confirm;
            armed_q      <= armed_q | ~confirm;
            first_q      <= first_d;
            code_q       <= code_d;
            fail_q       <= fail_d;
            timer_q      <= timer_d;
            dout_q       <= dout_d;
            en_left_q    <= en_left_d;
            en_right_q   <= en_right_d;
            err_q        <= err_d;
            prog_done_q  <= prog_done_d;
            unlocked_q   <= (state_d == OPEN);
            locked_out_q <= (state_d == LOCKOUT);
        end
    end

    assign dout      = dout_q;
    assign enLeft    = en_left_q;
    assign enRight   = en_right_q;
    assign unlocked  = unlocked_q;
    assign errPulse  = err_q;
    assign lockedOut = locked_out_q;
    assign progDone  = prog_done_q;
    assign failCnt   = fail_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed self-checking bench for code_lock_ctrl (default parameters).
module tb_code_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'd0;
    logic       confirm = 1'b0;
    logic       setCode = 1'b0;
    logic       lock = 1'b0;
    logic [3:0] dout;
    logic       enLeft, enRight, unlocked, errPulse, lockedOut, progDone;
    logic [3:0] failCnt;

    int checks = 0;
    int errors = 0;

    code_lock_ctrl dut (
        .clk(clk), .rst(rst), .din(din), .confirm(confirm), .setCode(setCode), .lock(lock),
        .dout(dout), .enLeft(enLeft), .enRight(enRight), .unlocked(unlocked),
        .errPulse(errPulse), .lockedOut(lockedOut), .progDone(progDone), .failCnt(failCnt)
    );

    always #5 clk = ~clk;

    // Returns at the negedge after the sampling edge: strobes of this press are visible.
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        din = d;
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
    endtask

    task automatic pulse_lock();
        @(negedge clk);
        lock = 1'b1;
        @(negedge clk);
        lock = 1'b0;
    endtask

    task automatic pulse_set();
        @(negedge clk);
        setCode = 1'b1;
        @(negedge clk);
        setCode = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] got;
        int cnt;
        confirm = 1'b1;
        #12;
        got = {dout, enLeft, enRight, unlocked, errPulse, lockedOut, progDone, failCnt, 1'b0};
        checks++;
        if (got !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (enLeft === 1'b1) cnt++;
        end
        checks++;
        if (cnt !== 0) begin
            errors++;
            $display("FAIL held_through_reset enLeft_count=%0d exp=0", cnt);
        end
        confirm = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unlock();
        press(4'd3);
        checks++;
        if ({enLeft, enRight, dout} !== {1'b1, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL first_press L/R/dout=%b%b/%h exp=10/3", enLeft, enRight, dout);
        end
        press(4'd5);
        checks++;
        if ({enLeft, enRight, dout, unlocked} !== {1'b0, 1'b1, 4'd5, 1'b0}) begin
            errors++;
            $display("FAIL second_press L/R/dout/unl=%b%b/%h/%b exp=01/5/0", enLeft, enRight, dout, unlocked);
        end
        @(negedge clk);
        checks++;
        if ({unlocked, errPulse, enRight, failCnt} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL open_result unl/err/R/fail=%b/%b/%b/%0d exp=1/0/0/0", unlocked, errPulse, enRight, failCnt);
        end
        press(4'd7);
        checks++;
        if ({enLeft, enRight, dout, unlocked} !== {1'b0, 1'b0, 4'd5, 1'b1}) begin
            errors++;
            $display("FAIL press_in_open L/R/dout/unl=%b%b/%h/%b exp=00/5/1", enLeft, enRight, dout, unlocked);
        end
        pulse_lock();
        checks++;
        if (unlocked !== 1'b0) begin
            errors++;
            $display("FAIL relock unlocked=%b exp=0", unlocked);
        end
    endtask

    task automatic test_lockout();
        for (int a = 1; a <= 3; a++) begin
            press(4'd1);
            press(4'd2);
            @(negedge clk);
            checks++;
            if ({errPulse, failCnt, lockedOut, unlocked} !== {1'b1, 4'(a), (a == 3), 1'b0}) begin
                errors++;
                $display("FAIL attempt%0d err/fail/lo/unl=%b/%0d/%b/%b", a, errPulse, failCnt, lockedOut, unlocked);
            end
        end
        for (int i = 0; i < 15; i++) begin
            confirm = i[0];
            din = 4'd9;
            @(negedge clk);
            checks++;
            if ({lockedOut, enLeft, enRight, errPulse, dout} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd2}) begin
                errors++;
                $display("FAIL lockout_cyc%0d lo/L/R/err/dout=%b/%b%b/%b/%h exp=1/00/0/2", i, lockedOut, enLeft, enRight, errPulse, dout);
            end
        end
        confirm = 1'b0;
        @(negedge clk);
        checks++;
        if ({lockedOut, failCnt} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL lockout_end lo/fail=%b/%0d exp=0/0", lockedOut, failCnt);
        end
    endtask

    task automatic test_program();
        press(4'd3);
        press(4'd5);
        @(negedge clk);
        pulse_set();
        checks++;
        if (unlocked !== 1'b0) begin
            errors++;
            $display("FAIL enter_prog unlocked=%b exp=0", unlocked);
        end
        press(4'd9);
        checks++;
        if ({enLeft, dout, progDone} !== {1'b1, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL prog_p1 L/dout/pd=%b/%h/%b exp=1/9/0", enLeft, dout, progDone);
        end
        press(4'd4);
        checks++;
        if ({enRight, dout, progDone, unlocked} !== {1'b1, 4'd4, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL prog_p2 R/dout/pd/unl=%b/%h/%b/%b exp=1/4/1/1", enRight, dout, progDone, unlocked);
        end
        @(negedge clk);
        checks++;
        if (progDone !== 1'b0) begin
            errors++;
            $display("FAIL progdone_width pd=%b exp=0", progDone);
        end
        pulse_lock();
        press(4'd9);
        press(4'd4);
        @(negedge clk);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL new_code_unlock unlocked=%b exp=1", unlocked);
        end
        pulse_lock();
        press(4'd3);
        press(4'd5);
        @(negedge clk);
        checks++;
        if ({errPulse, failCnt, unlocked} !== {1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL old_code_rejected err/fail/unl=%b/%0d/%b exp=1/1/0", errPulse, failCnt, unlocked);
        end
        press(4'd9);
        press(4'd4);
        @(negedge clk);
        pulse_set();
        press(4'd1);
        @(negedge clk);
        din = 4'd2;
        confirm = 1'b1;
        lock = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        lock = 1'b0;
        checks++;
        if ({enRight, progDone, unlocked, failCnt} !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL prog2_lock R/pd/unl/fail=%b/%b/%b/%0d exp=0/0/0/0", enRight, progDone, unlocked, failCnt);
        end
        press(4'd9);
        press(4'd4);
        @(negedge clk);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL code_kept_after_lock unlocked=%b exp=1", unlocked);
        end
        pulse_lock();
    endtask

    task automatic test_hold_and_priority();
        int cnt;
        cnt = 0;
        @(negedge clk);
        din = 4'd9;
        confirm = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (enLeft === 1'b1) cnt++;
        end
        confirm = 1'b0;
        checks++;
        if (cnt !== 1) begin
            errors++;
            $display("FAIL hold_confirm enLeft_count=%0d exp=1", cnt);
        end
        press(4'd4);
        @(negedge clk);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL hold_then_unlock unlocked=%b exp=1", unlocked);
        end
        @(negedge clk);
        lock = 1'b1;
        setCode = 1'b1;
        @(negedge clk);
        lock = 1'b0;
        setCode = 1'b0;
        checks++;
        if (unlocked !== 1'b0) begin
            errors++;
            $display("FAIL lock_setcode unlocked=%b exp=0", unlocked);
        end
        press(4'd9);
        press(4'd4);
        checks++;
        if (progDone !== 1'b0) begin
            errors++;
            $display("FAIL lock_over_setcode progDone=%b exp=0", progDone);
        end
        @(negedge clk);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_lock unlocked=%b exp=1", unlocked);
        end
        pulse_lock();
    endtask

    task automatic test_reset_mid();
        logic [14:0] got;
        for (int a = 0; a < 3; a++) begin
            press(4'd1);
            press(4'd2);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (lockedOut !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_lockout lo=%b exp=1", lockedOut);
        end
        #2 rst = 1'b1;
        #1;
        got = {dout, enLeft, enRight, unlocked, errPulse, lockedOut, progDone, failCnt, 1'b0};
        checks++;
        if (got !== 15'd0) begin
            errors++;
            $display("FAIL reset_in_lockout got=%h exp=0", got);
        end
        @(negedge clk);
        rst = 1'b0;
        press(4'd3);
        press(4'd5);
        @(negedge clk);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL default_code_restored unlocked=%b exp=1", unlocked);
        end
        pulse_set();
        press(4'd7);
        #2 rst = 1'b1;
        #1;
        got = {dout, enLeft, enRight, unlocked, errPulse, lockedOut, progDone, failCnt, 1'b0};
        checks++;
        if (got !== 15'd0) begin
            errors++;
            $display("FAIL reset_in_prog2 got=%h exp=0", got);
        end
        @(negedge clk);
        rst = 1'b0;
        press(4'd3);
        press(4'd5);
        @(negedge clk);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL unlock_after_prog_reset unlocked=%b exp=1", unlocked);
        end
        pulse_lock();
    endtask

`ifdef CODE_LOCK_TIMEOUT_EN
    task automatic test_timeout();
        int errs_seen;
        errs_seen = 0;
        press(4'd3);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (errPulse === 1'b1) errs_seen++;
        end
        checks++;
        if ({errs_seen[3:0], failCnt} !== {4'd0, 4'd0}) begin
            errors++;
            $display("FAIL timeout_abort errs=%0d fail=%0d exp=0/0", errs_seen, failCnt);
        end
        press(4'd3);
        press(4'd5);
        @(negedge clk);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL timeout_then_unlock unlocked=%b exp=1", unlocked);
        end
        pulse_lock();
    endtask
`endif

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_program();
        test_hold_and_priority();
        test_reset_mid();
`ifdef CODE_LOCK_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
Controller for the two-digit code-entry datapath. It sequences the left/right 4-bit digit registers from a keypad nibble (din) qualified by a confirm key. It compares the entered pair against a stored code and grants or denies access. It also counts failed attempts, enforces a lockout period, and allows the code to be reprogrammed while unlocked.

Parameters:
DEFAULT_CODE, 8'h35, code after reset; [7:4]=left digit, [3:0]=right digit
MAX_FAIL, 3, consecutive mismatches that trigger lockout (1..15)
LOCK_CYCLES, 16, lockout duration in clk cycles (>=1)
IDLE_TIMEOUT, 64, cycles without confirm before a partial entry aborts (optional feature only)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
din  input  4  keypad digit
confirm  input  1  confirm key, level; an internal rising-edge detect makes one press = one event
setCode  input  1  request reprogramming; honoured only in OPEN
lock  input  1  relock request; honoured in OPEN, PROG1, PROG2
dout  output  4  digit to left/right registers, registered copy of din at accepted press
enLeft  output  1  one-cycle load strobe for left register
enRight  output  1  one-cycle load strobe for right register
unlocked  output  1  high while in OPEN
errPulse  output  1  one-cycle pulse on mismatch
lockedOut  output  1  high while in LOCKOUT
progDone  output  1  one-cycle pulse when a new code is stored
failCnt  output  4  current consecutive-failure count

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high.
- Reset values:
  - state=IDLE; all outputs 0; stored code=DEFAULT_CODE; edge-detect register=0.
  - A press held through reset release is not counted until confirm falls and rises again.
- Press: a press is detected in cycle t when confirm=1 and confirm_q=0. Its effects appear on the clk edge ending cycle t:
  - dout<=din and the strobe are registered together.
  - Strobes last exactly one cycle.
- States:
  - IDLE: press -> latch d1, enLeft=1, go to GOT1.
  - GOT1: press -> latch d2, enRight=1, go to CHECK.
  - CHECK (1 cycle): compare {d1,d2} with the stored code.
    - Match -> OPEN, failCnt<=0.
    - Mismatch with failCnt+1 < MAX_FAIL -> failCnt++, errPulse, go to IDLE.
    - Mismatch with failCnt+1 == MAX_FAIL -> errPulse, failCnt<=MAX_FAIL, go to LOCKOUT, load timer with LOCK_CYCLES-1.
  - Timing of CHECK result: unlocked, errPulse and lockedOut appear 2 cycles after the second press is sampled.
  - LOCKOUT: presses are ignored (no strobes). Timer decrements each cycle. At 0 -> IDLE, failCnt<=0. lockedOut is high for exactly LOCK_CYCLES cycles.
  - OPEN:
    - lock -> IDLE.
    - else setCode -> PROG1.
    - Presses in OPEN are ignored.
  - PROG1: press -> p1, enLeft. lock -> IDLE, code unchanged.
  - PROG2: press -> p2, enRight, code<={p1,p2}, progDone, go to OPEN. lock -> IDLE, code unchanged.
- Simultaneous events:
  - lock has priority over setCode and over a press in the same cycle.
  - A press and lock together in PROG2 do not store the code.
- failCnt saturates at MAX_FAIL. It is not cleared by lock or reprogramming, only by a match or lockout expiry.
- Asynchronous reset mid-entry, mid-lockout or mid-program returns the block to its reset state immediately. The code reverts to DEFAULT_CODE.

Optional Feature:
- Macro CODE_LOCK_TIMEOUT_EN.
- Defined: a counter runs in GOT1, PROG1 and PROG2 and is cleared on every accepted press. After IDLE_TIMEOUT cycles without a press:
  - GOT1 -> IDLE, no failure counted, errPulse not asserted.
  - PROG1/PROG2 -> OPEN, code unchanged.
- Undefined: no counter; partial entries wait indefinitely.

Test Plan:
- Reset, then presses 3 then 5 -> enLeft with dout=3, then enRight with dout=5. unlocked=1 two cycles after the second press. failCnt=0.
- Enter 1,2 three times -> errPulse after the first two attempts with failCnt 1,2. Third attempt -> lockedOut=1 for 16 cycles, presses ignored, then IDLE with failCnt=0.
- In OPEN: setCode, press 9, press 4 -> progDone. Relock and enter 9,4 -> unlocked. Entering 3,5 -> errPulse.
- Hold confirm high for 10 cycles in IDLE -> exactly one enLeft. lock and setCode together in OPEN -> IDLE.
- Assert rst in LOCKOUT and in PROG2 -> all outputs 0 immediately. Code back to 8'h35; entering 3,5 unlocks.
- With CODE_LOCK_TIMEOUT_EN defined: press 3, then wait 64 cycles -> back to IDLE, failCnt unchanged, then entering 3,5 unlocks.
